// File: rtl/alu_issue_sched.sv
// ALU issue scheduler: holds dispatched ops, wakes operands from the CDB, issues one READY op per cycle.
// Optional ALU_ISSUE_AGE_EN: oldest-first select instead of round-robin.
module alu_issue_sched #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid_in,
  input  logic [5:0]       disp_op_in,
  input  logic [31:0]      disp_vi_in,
  input  logic [31:0]      disp_vj_in,
  input  logic             disp_qi_valid_in,
  input  logic             disp_qj_valid_in,
  input  logic [TAG_W-1:0] disp_qi_in,
  input  logic [TAG_W-1:0] disp_qj_in,
  input  logic [31:0]      disp_imm_in,
  input  logic [31:0]      disp_pc_in,
  input  logic [4:0]       disp_rd_in,
  input  logic             disp_itype_in,
  output logic             full_out,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_val_in,
  output logic [5:0]       alu_op_out,
  output logic [31:0]      alu_vi_out,
  output logic [31:0]      alu_vj_out,
  output logic [31:0]      alu_imm_out,
  output logic [31:0]      alu_pc_out,
  output logic [4:0]       alu_rd_out,
  output logic             alu_itype_out
);
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(ENTRIES);

  typedef enum logic [1:0] {E_FREE = 2'd0, E_WAIT = 2'd1, E_READY = 2'd2} ent_t;

  ent_t              st_q    [ENTRIES];
  logic [ENTRIES-1:0] qiv_q, qjv_q, itype_q;
  logic [TAG_W-1:0]  qi_q    [ENTRIES];
  logic [TAG_W-1:0]  qj_q    [ENTRIES];
  logic [DATA_W-1:0] vi_q    [ENTRIES];
  logic [DATA_W-1:0] vj_q    [ENTRIES];
  logic [DATA_W-1:0] imm_q   [ENTRIES];
  logic [DATA_W-1:0] pc_q    [ENTRIES];
  logic [5:0]        op_q    [ENTRIES];
  logic [4:0]        rd_q    [ENTRIES];

  logic [ENTRIES-1:0] hit_i, hit_j;
  logic [IDX_W-1:0]   disp_idx, sel_idx;
  logic               have_free, sel_vld, disp_fire;
  logic               dcap_i, dcap_j, dpend_i, dpend_j;

`ifdef ALU_ISSUE_AGE_EN
  logic [IDX_W-1:0] rank_q [ENTRIES];
  logic [IDX_W:0]   occ;
  logic [IDX_W-1:0] new_rank;
`else
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
`endif

  // Free-slot search, wake-up match and dispatch-time CDB capture
  always_comb begin
    have_free = 1'b0;
    disp_idx  = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (st_q[e] == E_FREE) begin
        have_free = 1'b1;
        disp_idx  = IDX_W'(e);
      end
    end
    for (int e = 0; e < ENTRIES; e++) begin
      hit_i[e] = cdb_valid_in && (st_q[e] == E_WAIT) && qiv_q[e] && (qi_q[e] == cdb_tag_in);
      hit_j[e] = cdb_valid_in && (st_q[e] == E_WAIT) && qjv_q[e] && (qj_q[e] == cdb_tag_in);
    end
    dcap_i    = disp_qi_valid_in && cdb_valid_in && (disp_qi_in == cdb_tag_in);
    dcap_j    = disp_qj_valid_in && cdb_valid_in && (disp_qj_in == cdb_tag_in);
    dpend_i   = disp_qi_valid_in && !dcap_i;
    dpend_j   = disp_qj_valid_in && !dcap_j;
    disp_fire = rdy_in && !flush_in && disp_valid_in && have_free;
  end

  assign full_out = !have_free;

`ifdef ALU_ISSUE_AGE_EN
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    occ     = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (st_q[e] != E_FREE) occ = occ + (IDX_W+1)'(1);
      if (st_q[e] == E_READY && (!sel_vld || rank_q[e] < rank_q[sel_idx])) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(e);
      end
    end
    new_rank = IDX_W'(occ - (IDX_W+1)'(sel_vld));
  end
`else
  // Round-robin: first READY entry at or after the pointer, wrapping
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (st_q[cand] == E_READY) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end
`endif

  // Control state and issue register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int e = 0; e < ENTRIES; e++) st_q[e] <= E_FREE;
      qiv_q         <= '0;
      qjv_q         <= '0;
      alu_op_out    <= '0;
      alu_vi_out    <= '0;
      alu_vj_out    <= '0;
      alu_imm_out   <= '0;
      alu_pc_out    <= '0;
      alu_rd_out    <= '0;
      alu_itype_out <= 1'b0;
`ifdef ALU_ISSUE_AGE_EN
      for (int e = 0; e < ENTRIES; e++) rank_q[e] <= '0;
`else
      ptr_q <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int e = 0; e < ENTRIES; e++) st_q[e] <= E_FREE;
        alu_op_out <= '0;
`ifndef ALU_ISSUE_AGE_EN
        ptr_q <= '0;
`endif
      end else begin
        if (sel_vld) begin
          alu_op_out    <= op_q[sel_idx];
          alu_vi_out    <= vi_q[sel_idx];
          alu_vj_out    <= vj_q[sel_idx];
          alu_imm_out   <= imm_q[sel_idx];
          alu_pc_out    <= pc_q[sel_idx];
          alu_rd_out    <= rd_q[sel_idx];
          alu_itype_out <= itype_q[sel_idx];
          st_q[sel_idx] <= E_FREE;
`ifdef ALU_ISSUE_AGE_EN
          for (int e = 0; e < ENTRIES; e++) begin
            if (st_q[e] != E_FREE && rank_q[e] > rank_q[sel_idx]) rank_q[e] <= rank_q[e] - IDX_W'(1);
          end
`else
          ptr_q <= sel_idx + IDX_W'(1);
`endif
        end else begin
          alu_op_out <= '0;
        end
        for (int e = 0; e < ENTRIES; e++) begin
          if (st_q[e] == E_WAIT) begin
            if (hit_i[e]) qiv_q[e] <= 1'b0;
            if (hit_j[e]) qjv_q[e] <= 1'b0;
            if ((!qiv_q[e] || hit_i[e]) && (!qjv_q[e] || hit_j[e])) st_q[e] <= E_READY;
          end
        end
        if (disp_fire) begin
          st_q[disp_idx]  <= (dpend_i || dpend_j) ? E_WAIT : E_READY;
          qiv_q[disp_idx] <= dpend_i;
          qjv_q[disp_idx] <= dpend_j;
`ifdef ALU_ISSUE_AGE_EN
          rank_q[disp_idx] <= new_rank;
`endif
        end
      end
    end
  end

  // Entry payload: written on dispatch and operand capture only
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (hit_i[e]) vi_q[e] <= cdb_val_in;
        if (hit_j[e]) vj_q[e] <= cdb_val_in;
      end
      if (disp_fire) begin
        op_q[disp_idx]    <= disp_op_in;
        vi_q[disp_idx]    <= dcap_i ? cdb_val_in : disp_vi_in;
        vj_q[disp_idx]    <= dcap_j ? cdb_val_in : disp_vj_in;
        qi_q[disp_idx]    <= disp_qi_in;
        qj_q[disp_idx]    <= disp_qj_in;
        imm_q[disp_idx]   <= disp_imm_in;
        pc_q[disp_idx]    <= disp_pc_in;
        rd_q[disp_idx]    <= disp_rd_in;
        itype_q[disp_idx] <= disp_itype_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios plus random traffic against a behavioural scheduler model.
module tb_alu_issue_sched;
  localparam int E = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, disp_valid_in;
  logic [5:0]  disp_op_in;
  logic [31:0] disp_vi_in, disp_vj_in, disp_imm_in, disp_pc_in;
  logic        disp_qi_valid_in, disp_qj_valid_in, disp_itype_in;
  logic [3:0]  disp_qi_in, disp_qj_in, cdb_tag_in;
  logic [4:0]  disp_rd_in;
  logic        full_out, cdb_valid_in;
  logic [31:0] cdb_val_in;
  logic [5:0]  alu_op_out;
  logic [31:0] alu_vi_out, alu_vj_out, alu_imm_out, alu_pc_out;
  logic [4:0]  alu_rd_out;
  logic        alu_itype_out;

  alu_issue_sched #(.ENTRIES(E), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
    .disp_vi_in(disp_vi_in), .disp_vj_in(disp_vj_in),
    .disp_qi_valid_in(disp_qi_valid_in), .disp_qj_valid_in(disp_qj_valid_in),
    .disp_qi_in(disp_qi_in), .disp_qj_in(disp_qj_in),
    .disp_imm_in(disp_imm_in), .disp_pc_in(disp_pc_in), .disp_rd_in(disp_rd_in),
    .disp_itype_in(disp_itype_in), .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_val_in(cdb_val_in),
    .alu_op_out(alu_op_out), .alu_vi_out(alu_vi_out), .alu_vj_out(alu_vj_out),
    .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out), .alu_rd_out(alu_rd_out),
    .alu_itype_out(alu_itype_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a table of occupied slots with pending flags, plus the last issued op
  bit          m_v [E];
  bit          m_pi[E], m_pj[E], m_it[E];
  logic [3:0]  m_qi[E], m_qj[E];
  logic [31:0] m_vi[E], m_vj[E], m_imm[E], m_pc[E];
  logic [5:0]  m_op[E];
  logic [4:0]  m_rd[E];
  int          m_ptr;
`ifdef ALU_ISSUE_AGE_EN
  int          m_seq[E];
  int          m_seqc;
`endif
  logic [5:0]  x_op;
  logic [31:0] x_vi, x_vj, x_imm, x_pc;
  logic [4:0]  x_rd;
  logic        x_it;

  function automatic bit m_full();
    for (int i = 0; i < E; i++) if (!m_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < E; i++) m_v[i] = 1'b0;
    m_ptr = 0;
    x_op = '0; x_vi = '0; x_vj = '0; x_imm = '0; x_pc = '0; x_rd = '0; x_it = 1'b0;
  endtask

  task automatic m_step();
    int didx, sel;
    if (!rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < E; i++) m_v[i] = 1'b0;
      m_ptr = 0;
      x_op = '0;
      return;
    end
    didx = -1;
    for (int i = 0; i < E; i++) if (!m_v[i] && didx < 0) didx = i;
    sel = -1;
`ifdef ALU_ISSUE_AGE_EN
    for (int i = 0; i < E; i++)
      if (m_v[i] && !m_pi[i] && !m_pj[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
`else
    for (int k = 0; k < E; k++) begin
      int j;
      j = (m_ptr + k) % E;
      if (sel < 0 && m_v[j] && !m_pi[j] && !m_pj[j]) sel = j;
    end
`endif
    if (sel >= 0) begin
      x_op = m_op[sel]; x_vi = m_vi[sel]; x_vj = m_vj[sel]; x_imm = m_imm[sel];
      x_pc = m_pc[sel]; x_rd = m_rd[sel]; x_it = m_it[sel];
      m_v[sel] = 1'b0;
      m_ptr = (sel + 1) % E;
    end else begin
      x_op = '0;
    end
    if (cdb_valid_in) begin
      for (int i = 0; i < E; i++) begin
        if (m_v[i] && m_pi[i] && m_qi[i] == cdb_tag_in) begin m_vi[i] = cdb_val_in; m_pi[i] = 1'b0; end
        if (m_v[i] && m_pj[i] && m_qj[i] == cdb_tag_in) begin m_vj[i] = cdb_val_in; m_pj[i] = 1'b0; end
      end
    end
    if (disp_valid_in && didx >= 0) begin
      bit ci, cj;
      ci = disp_qi_valid_in && cdb_valid_in && disp_qi_in == cdb_tag_in;
      cj = disp_qj_valid_in && cdb_valid_in && disp_qj_in == cdb_tag_in;
      m_v[didx]  = 1'b1;
      m_op[didx] = disp_op_in;
      m_pi[didx] = disp_qi_valid_in && !ci;
      m_pj[didx] = disp_qj_valid_in && !cj;
      m_qi[didx] = disp_qi_in;
      m_qj[didx] = disp_qj_in;
      m_vi[didx] = ci ? cdb_val_in : disp_vi_in;
      m_vj[didx] = cj ? cdb_val_in : disp_vj_in;
      m_imm[didx] = disp_imm_in; m_pc[didx] = disp_pc_in;
      m_rd[didx] = disp_rd_in;   m_it[didx] = disp_itype_in;
`ifdef ALU_ISSUE_AGE_EN
      m_seq[didx] = m_seqc;
      m_seqc++;
`endif
    end
  endtask

  task automatic check_outputs();
    chk("alu_op", 32'(alu_op_out), 32'(x_op));
    chk("alu_vi", alu_vi_out, x_vi);
    chk("alu_vj", alu_vj_out, x_vj);
    chk("alu_imm", alu_imm_out, x_imm);
    chk("alu_pc", alu_pc_out, x_pc);
    chk("alu_rd", 32'(alu_rd_out), 32'(x_rd));
    chk("alu_itype", 32'(alu_itype_out), 32'(x_it));
    chk("full", 32'(full_out), 32'(m_full()));
  endtask

  task automatic drive(input bit dv, input logic [5:0] op, input logic [31:0] vi, input logic [31:0] vj,
                       input bit pi, input bit pj, input logic [3:0] qi, input logic [3:0] qj,
                       input bit cv, input logic [3:0] ct, input logic [31:0] cval,
                       input bit fl, input bit rdy);
    disp_valid_in = dv && !m_full();
    disp_op_in = op; disp_vi_in = vi; disp_vj_in = vj;
    disp_qi_valid_in = pi; disp_qj_valid_in = pj; disp_qi_in = qi; disp_qj_in = qj;
    disp_imm_in = $urandom; disp_pc_in = $urandom;
    disp_rd_in = 5'($urandom); disp_itype_in = 1'($urandom);
    cdb_valid_in = cv; cdb_tag_in = ct; cdb_val_in = cval;
    flush_in = fl; rdy_in = rdy;
    m_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 6'd0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v);
    drive(0, 6'd0, 0, 0, 0, 0, 4'd0, 4'd0, 1, t, v, 0, 1);
  endtask

  task automatic disp_pend(input logic [5:0] op, input logic [3:0] t);
    drive(1, op, 32'd1, 32'd2, 1, 0, t, 4'd0, 0, 4'd0, 0, 0, 1);
  endtask

  task automatic reset_pulse();
    rst_in = 1'b0;
    #2;
    m_reset();
    check_outputs();
    @(posedge clk_in);
    #1;
    check_outputs();
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; disp_valid_in = 1'b0;
    disp_op_in = '0; disp_vi_in = '0; disp_vj_in = '0; disp_imm_in = '0; disp_pc_in = '0;
    disp_qi_valid_in = 1'b0; disp_qj_valid_in = 1'b0; disp_qi_in = '0; disp_qj_in = '0;
    disp_rd_in = '0; disp_itype_in = 1'b0; cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_val_in = '0;
`ifdef ALU_ISSUE_AGE_EN
    m_seqc = 0;
`endif
    m_reset();
    repeat (2) @(posedge clk_in);
    #1;
    reset_pulse();

    // ADD 5,7 with both operands present
    drive(1, 6'd1, 32'd5, 32'd7, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);
    idle(2);
    // SUB waiting on tag 3; tag 4 must not wake it
    drive(1, 6'd2, 32'd0, 32'd20, 1, 0, 4'd3, 4'd0, 0, 4'd0, 0, 0, 1);
    cdb(4'd4, 32'd99);
    cdb(4'd3, 32'd10);
    idle(2);
    // Qj captured from the CDB in the dispatch cycle
    drive(1, 6'd3, 32'd4, 32'd0, 0, 1, 4'd0, 4'd2, 1, 4'd2, 32'hFFFF_FFFF, 0, 1);
    idle(2);
    // Fill all slots, wake together, drain in order
    for (int i = 0; i < E; i++) disp_pend(6'(10 + i), 4'd9);
    cdb(4'd9, 32'd55);
    idle(5);
    // Flush with a simultaneous dispatch and READY entries
    for (int i = 0; i < 3; i++) disp_pend(6'(20 + i), 4'd10);
    cdb(4'd10, 32'd66);
    drive(1, 6'd30, 32'd1, 32'd2, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1);
    idle(2);
    // rdy_in low freezes READY entries; a CDB during the stall is lost
    for (int i = 0; i < 2; i++) disp_pend(6'(40 + i), 4'd11);
    disp_pend(6'd42, 4'd12);
    cdb(4'd11, 32'd77);
    drive(0, 6'd0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 4'd12, 32'd88, 0, 0);
    repeat (2) drive(1, 6'd50, 32'd3, 32'd3, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);
    idle(4);
    cdb(4'd12, 32'd89);
    idle(2);
    // Reset mid-run with 3 entries occupied
    for (int i = 0; i < 3; i++) disp_pend(6'(60 + i), 4'd13);
    reset_pulse();
    drive(1, 6'd1, 32'd5, 32'd7, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        reset_pulse();
      end else begin
        drive(($urandom % 3) != 0, 6'($urandom_range(1, 63)), $urandom, $urandom,
              1'($urandom), 1'($urandom), 4'($urandom % 8), 4'($urandom % 8),
              1'($urandom), 4'($urandom % 8), $urandom,
              ($urandom % 50) == 0, ($urandom % 8) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler that shares the single-cycle ALU among a small pool of waiting instructions. Holds up to ENTRIES dispatched ALU/branch operations and captures missing operands from the common data bus (CDB). Each cycle it selects one entry whose operands are all present and drives the ALU's operation inputs from a register. It sits between the dispatch stage and the ALU; the ALU's `alu_op == 0` idle encoding is the "no issue" signal.

## Interface
- ENTRIES, 4, number of scheduler slots (power of two, 2..16)
- TAG_W, 4, width of producer tags carried on the CDB (ROB index)

- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state and outputs
- flush_in  in  1  misprediction flush; empties scheduler
- disp_valid_in  in  1  dispatch request this cycle
- disp_op_in  in  6  ALU opcode (nonzero)
- disp_vi_in / disp_vj_in  in  32  operand values when available
- disp_qi_valid_in / disp_qj_valid_in  in  1  operand still pending
- disp_qi_in / disp_qj_in  in  TAG_W  producer tag of pending operand
- disp_imm_in, disp_pc_in  in  32  immediate, instruction PC
- disp_rd_in  in  5  destination
- disp_itype_in  in  1  passed through to ALU
- full_out  out  1  no free entry; dispatch must not assert
- cdb_valid_in  in  1  CDB broadcast valid
- cdb_tag_in  in  TAG_W  broadcast tag
- cdb_val_in  in  32  broadcast value
- alu_op_out  out  6  opcode to ALU, 0 = idle
- alu_vi_out / alu_vj_out / alu_imm_out / alu_pc_out  out  32  ALU operands
- alu_rd_out  out  5; alu_itype_out  out  1

## Operation
- Per-entry state: FREE, WAIT (at least one operand pending), READY.
- Dispatch: writes lowest-index FREE entry. Pending operand whose tag equals the same-cycle CDB tag (cdb_valid_in) is captured from cdb_val_in and marked present. Entry goes to READY if both operands are present, else WAIT.
- Wake-up: each WAIT entry compares Qi/Qj against the CDB; a match latches the value and clears the pending bit; WAIT→READY when both are clear.
- Select: round-robin among READY entries, starting at index after last issued (pointer resets to 0). Chosen entry's fields are registered to alu_*_out; the entry becomes FREE at the same edge. No READY entry → alu_op_out <= 0; other outputs hold.
- full_out is combinational from current state: all entries non-FREE. A slot freed by issue is dispatchable next cycle, not same cycle.
- Dispatch while full_out = 1: ignored (bench asserts it never happens).
- flush_in: all entries FREE, alu_op_out <= 0, pointer <= 0. Flush has priority over dispatch, wake-up and issue in that cycle.
- rdy_in low: no dispatch, wake-up, issue or flush takes effect; outputs hold. CDB broadcasts during rdy_in low are lost; the producer re-broadcasts.
- Reset (rst_in low, any time): all entries FREE, pointer 0, every output 0. full_out = 0.

## Timing
- Dispatch with operands present at edge t → eligible at edge t+1 → alu_op_out valid after t+1 → ALU result registered at t+2.
- CDB match at edge t on a WAIT entry → issue earliest at edge t+1. The same-cycle CDB value is not forwarded to the issue path.
- Throughput: one issue per cycle. Dispatch and issue of different entries proceed in the same cycle.

## Configuration
- ALU_ISSUE_AGE_EN defined: select replaces round-robin with oldest-first. Each entry carries an age rank (0 = oldest), and the lowest rank among READY entries is issued. Ranks of younger entries decrement on issue, and a new entry gets rank = occupancy.
- ALU_ISSUE_AGE_EN undefined: round-robin as described; no age storage.

## Test plan
- Reset mid-run with 3 entries occupied → next cycle full_out=0, alu_op_out=0; dispatch of ADD 5,7 issues alu_op_out=ADD, vi=5, vj=7 one cycle later.
- Dispatch SUB with Qi=3 pending, CDB tag 3 value 10 two cycles later → issue on the following edge with vi=10; a non-matching tag 4 causes no wake-up.
- Dispatch with Qj=2 in the same cycle as CDB tag 2 value 0xFFFF_FFFF → entry READY immediately, issues next edge with vj=0xFFFF_FFFF.
- Fill 4 entries with ready ops A,B,C,D → full_out=1; issue order A,B,C,D over 4 cycles, one per cycle. full_out deasserts after the first issue. With ALU_ISSUE_AGE_EN and out-of-order wake-up, the oldest READY entry issues first.
- flush_in asserted with a simultaneous dispatch and 2 READY entries → next cycle alu_op_out=0, all FREE, dispatched op dropped.
- rdy_in low for 3 cycles with READY entries → alu_* outputs and state unchanged; issue resumes on the first edge with rdy_in high.
